// File: rtl/passcode_checker_pkg.sv
// Shared passcode definitions: FSM state encoding, BCD digit width, and the
// per-cycle strobe bundle seen by the checker.
package passcode_checker_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_SET    = 2'd2,
    ST_ALARM  = 2'd3
  } pc_state_e;

  typedef struct packed {
    logic               clear;
    logic               confirm;
    logic               set_mode;
    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
  } pc_req_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/passcode_checker_if.sv
// Strobe inputs from the decoder side and status outputs of the checker.
interface passcode_checker_if;
  import passcode_checker_pkg::*;

  logic [DIGIT_W-1:0] digit;
  logic               digit_valid;
  logic               confirm;
  logic               clear;
  logic               set_mode;
  logic               unlocked;
  logic               setting;
  logic               alarm;
  logic [3:0]         entry_count;
  logic [1:0]         fail_count;
  logic               ok_pulse;
  logic               err_pulse;

  modport master (
    output digit, digit_valid, confirm, clear, set_mode,
    input  unlocked, setting, alarm, entry_count, fail_count, ok_pulse, err_pulse
  );

  modport slave (
    input  digit, digit_valid, confirm, clear, set_mode,
    output unlocked, setting, alarm, entry_count, fail_count, ok_pulse, err_pulse
  );
endinterface

// File: rtl/passcode_checker_lockout_timer.sv
// Alarm lockout down-counter: load starts it at LOCK_CYCLES-1, done is high in
// the cycle the count sits at zero, after which it goes idle.
module lockout_timer #(
  parameter int LOCK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  localparam int CW = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOCK_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          run;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= LOAD_VAL;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign done = run && (cnt == '0);
endmodule

// File: rtl/passcode_checker.sv
// Passcode engine: accumulates BCD digits, checks/stores codes, and locks out
// after MAX_FAIL consecutive bad confirms.
module passcode_checker
  import passcode_checker_pkg::*;
#(
  parameter int                       CODE_LEN     = 4,
  parameter logic [4*CODE_LEN-1:0]    DEFAULT_CODE = 16'h1234,
  parameter int                       MAX_FAIL     = 3,
  parameter int                       LOCK_CYCLES  = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  passcode_checker_if.slave  pc
);
  localparam int             BW   = DIGIT_W * CODE_LEN;
  localparam logic [3:0]     FULL = 4'(CODE_LEN);
  localparam logic [1:0]     MAXF = 2'(MAX_FAIL);

  pc_state_e   state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [BW-1:0] code_q, code_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  fail_q, fail_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        tmr_load, tmr_done;
  pc_req_t     req;
  logic        full, match, accept;
  logic [1:0]  fail_inc;

  assign req = '{clear:       pc.clear,
                 confirm:     pc.confirm,
                 set_mode:    pc.set_mode,
                 digit_valid: pc.digit_valid,
                 digit:       pc.digit};

  assign full     = (cnt_q == FULL);
  assign match    = full && (buf_q == code_q);
  assign fail_inc = fail_q + 2'd1;
  // digit_valid is the lowest-priority strobe; any other strobe drops it
  assign accept   = (state_q == ST_LOCKED || state_q == ST_SET) &&
                    req.digit_valid && !req.clear && !req.confirm &&
                    !req.set_mode && !full && is_bcd(req.digit);

  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .done (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    code_d   = code_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;

    if (accept) begin
      buf_d = {buf_q[BW-DIGIT_W-1:0], req.digit};
      cnt_d = cnt_q + 4'd1;
    end

    case (state_q)
      ST_LOCKED: begin
        if (req.clear) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (req.confirm) begin
          buf_d = '0;
          cnt_d = '0;
          if (match) begin
            state_d = ST_OPEN;
            fail_d  = '0;
            ok_d    = 1'b1;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_inc;
            if (fail_inc == MAXF) begin
              state_d  = ST_ALARM;
              tmr_load = 1'b1;
            end
          end
        end
      end
      ST_OPEN: begin
        if (!req.clear) begin
          if (req.confirm) begin
            state_d = ST_LOCKED;
          end else if (req.set_mode) begin
            state_d = ST_SET;
            buf_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_SET: begin
        if (req.clear) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (req.confirm) begin
          buf_d = '0;
          cnt_d = '0;
          if (full) begin
            code_d  = buf_q;
            state_d = ST_OPEN;
            ok_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ALARM: begin
        if (tmr_done) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOCKED;
      buf_q   <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      fail_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign pc.unlocked    = (state_q == ST_OPEN) || (state_q == ST_SET);
  assign pc.setting     = (state_q == ST_SET);
  assign pc.alarm       = (state_q == ST_ALARM);
  assign pc.entry_count = cnt_q;
  assign pc.fail_count  = fail_q;
  assign pc.ok_pulse    = ok_q;
  assign pc.err_pulse   = err_q;
endmodule

// File: tb/tb_passcode_checker.sv
// Checks passcode_checker against a digit-queue reference model, directed
// scenarios first, then random strobes biased toward the stored code.
module tb_passcode_checker;
  localparam int CODE_LEN = 4;
  localparam int MAX_FAIL = 3;
  localparam int LOCK     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  passcode_checker_if bus();

  passcode_checker #(
    .CODE_LEN(CODE_LEN), .DEFAULT_CODE(16'h1234),
    .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pc  (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  int alarm_cycles = 0;

  // reference model: mode 0 locked, 1 open, 2 set, 3 alarm
  int m_mode;
  int m_q[$];
  int m_code[CODE_LEN];
  int m_fail;
  int m_left;
  bit m_ok, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_q.delete();
    m_code = '{1, 2, 3, 4};
    m_fail = 0;
    m_left = 0;
    m_ok   = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input bit r, input bit dv, input int d,
                            input bit cf, input bit cl, input bit sm);
    bit hit;
    m_ok  = 0;
    m_err = 0;
    if (r) begin
      model_reset();
      return;
    end
    if (m_mode == 3) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 0;
        m_fail = 0;
      end
    end else if (cl) begin
      if (m_mode != 1) m_q.delete();
    end else if (cf) begin
      if (m_mode == 0) begin
        hit = (m_q.size() == CODE_LEN);
        for (int i = 0; i < m_q.size(); i++) if (m_q[i] != m_code[i]) hit = 0;
        if (hit) begin
          m_mode = 1; m_fail = 0; m_ok = 1;
        end else begin
          m_err = 1; m_fail++;
          if (m_fail == MAX_FAIL) begin
            m_mode = 3; m_left = LOCK;
          end
        end
        m_q.delete();
      end else if (m_mode == 1) begin
        m_mode = 0;
      end else begin
        if (m_q.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_q[i];
          m_mode = 1; m_ok = 1;
        end else begin
          m_err = 1;
        end
        m_q.delete();
      end
    end else if (sm) begin
      if (m_mode == 1) begin
        m_mode = 2;
        m_q.delete();
      end
    end else if (dv && m_mode != 1 && m_q.size() < CODE_LEN && d <= 9) begin
      m_q.push_back(d);
    end
  endtask

  task automatic cyc(input bit r, input bit dv, input int d,
                     input bit cf, input bit cl, input bit sm);
    @(negedge clk);
    chk("unlocked",    bus.unlocked,    32'(m_mode == 1 || m_mode == 2));
    chk("setting",     bus.setting,     32'(m_mode == 2));
    chk("alarm",       bus.alarm,       32'(m_mode == 3));
    chk("entry_count", bus.entry_count, m_q.size());
    chk("fail_count",  bus.fail_count,  m_fail);
    chk("ok_pulse",    bus.ok_pulse,    32'(m_ok));
    chk("err_pulse",   bus.err_pulse,   32'(m_err));
    if (bus.alarm === 1'b1) alarm_cycles++;
    rst             = r;
    bus.digit_valid = dv;
    bus.digit       = 4'(d);
    bus.confirm     = cf;
    bus.clear       = cl;
    bus.set_mode    = sm;
    @(posedge clk);
    model_step(r, dv, d, cf, cl, sm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  task automatic key(input int d);
    cyc(0, 1, d, 0, 0, 0);
  endtask
  task automatic conf();
    cyc(0, 0, 0, 1, 0, 0);
  endtask
  task automatic keys(input int a, input int b, input int c, input int e);
    key(a); key(b); key(c); key(e);
  endtask

  initial begin
    bus.digit = 0; bus.digit_valid = 0; bus.confirm = 0;
    bus.clear = 0; bus.set_mode = 0;
    repeat (2) @(posedge clk);
    model_reset();
    cyc(1, 0, 0, 0, 0, 0);
    idle(1);

    // correct code unlocks
    keys(1, 2, 3, 4); conf();
    #1 chk("unlock_ok", bus.ok_pulse, 1);
    chk("unlock_state", bus.unlocked, 1);
    idle(1);
    #1 chk("ok_one_cycle", bus.ok_pulse, 0);
    conf(); idle(1);

    // short entry fails; over-long entry ignores the fifth digit
    key(1); key(2); key(3); conf();
    #1 chk("short_err", bus.err_pulse, 1);
    chk("short_fail", bus.fail_count, 1);
    keys(1, 2, 3, 4); key(5); key(12); conf();
    #1 chk("long_ok", bus.unlocked, 1);
    conf(); idle(1);

    // three wrong confirms -> timed alarm, strobes ignored
    alarm_cycles = 0;
    key(9); conf(); conf(); conf();
    key(1); key(2); conf(); cyc(0, 1, 3, 1, 1, 1);
    idle(10);
    chk("alarm_len", alarm_cycles, LOCK);
    chk("alarm_fail_clr", bus.fail_count, 0);

    // code change
    keys(1, 2, 3, 4); conf();
    cyc(0, 0, 0, 0, 0, 1);
    keys(9, 8, 7, 6); conf();
    #1 chk("set_ok", bus.ok_pulse, 1);
    conf();
    keys(1, 2, 3, 4); conf();
    #1 chk("old_code_err", bus.err_pulse, 1);
    keys(9, 8, 7, 6); conf();
    #1 chk("new_code_ok", bus.unlocked, 1);
    conf();

    // strobe priority
    cyc(0, 1, 5, 0, 1, 0);
    #1 chk("clr_beats_digit", bus.entry_count, 0);
    keys(9, 8, 7, 6);
    cyc(0, 1, 1, 1, 0, 0);
    #1 chk("cf_beats_digit", bus.entry_count, 0);
    chk("cf_unlock", bus.unlocked, 1);

    // reset in SET restores default code
    cyc(0, 0, 0, 0, 0, 1); key(4);
    cyc(1, 0, 0, 0, 0, 0);
    #1 chk("rst_set", bus.setting, 0);
    keys(1, 2, 3, 4); conf();
    #1 chk("default_back", bus.unlocked, 1);
    conf();

    // reset in ALARM
    conf(); conf(); conf(); idle(3);
    cyc(1, 0, 0, 0, 0, 0);
    #1 chk("rst_alarm", bus.alarm, 0);
    idle(1);

    // random phase
    for (int n = 0; n < 2000; n++) begin
      bit r, dv, cf, cl, sm;
      int d;
      r  = ($urandom_range(0, 299) == 0);
      dv = ($urandom_range(0, 1) == 1);
      cf = ($urandom_range(0, 99) < 9);
      cl = ($urandom_range(0, 99) < 3);
      sm = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 9) < 6 && m_q.size() < CODE_LEN)
        d = m_code[m_q.size()];
      else
        d = $urandom_range(0, 15);
      cyc(r, dv, d, cf, cl, sm);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
